// File: rtl/alu_sequencer.sv
// alu_sequencer: decodes instruction words, drives ALU operands and retires results; ALU_SEQ_OVERLAP_EN accepts the next instruction during WB
module alu_sequencer #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_opcode,
  output logic [3:0]        alu_cond,
  output logic              alu_s,
  output logic [2:0]        alu_sr_cont,
  output logic [4:0]        alu_sr_bit,
  output logic [15:0]       alu_imm,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_flags,
  output logic              res_valid,
  output logic              res_wr,
  output logic [3:0]        res_rd,
  output logic [DATA_W-1:0] res_data,
  output logic [3:0]        flags,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [3:0] r_rd;
  logic w_accept, w_cond_met, w_wr, w_fl;
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb w_next = r_state == EXEC ? WB : w_accept ? EXEC : IDLE;
  always_comb begin
`ifdef ALU_SEQ_OVERLAP_EN
    instr_ready = r_state == IDLE || r_state == WB;
`else
    instr_ready = r_state == IDLE;
`endif
    w_accept = instr_valid && instr_ready;
  end
  // condition compares the latched operands, not the ALU result
  always_comb begin
    w_cond_met = 1'b0;
    case (alu_cond)
      4'b0000: w_cond_met = 1'b1;
      4'b0001: w_cond_met = alu_in1 == alu_in2;
      4'b0010: w_cond_met = $signed(alu_in1) >  $signed(alu_in2);
      4'b0011: w_cond_met = $signed(alu_in1) <  $signed(alu_in2);
      4'b0100: w_cond_met = $signed(alu_in1) >= $signed(alu_in2);
      4'b0101: w_cond_met = $signed(alu_in1) <= $signed(alu_in2);
      4'b0110: w_cond_met = alu_in1 >  alu_in2;
      4'b0111: w_cond_met = alu_in1 <  alu_in2;
      4'b1000: w_cond_met = alu_in1 >= alu_in2;
      default: w_cond_met = 1'b0;
    endcase
    w_wr = r_state == EXEC && w_cond_met && (!alu_opcode[3] || alu_opcode == 4'b1101);
    w_fl = r_state == EXEC && w_cond_met && (alu_s || alu_opcode == 4'b1011);
  end
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_rd        <= '0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_opcode  <= '0;
      alu_cond    <= '0;
      alu_s       <= 1'b0;
      alu_sr_cont <= '0;
      alu_sr_bit  <= '0;
      alu_imm     <= '0;
      res_valid   <= 1'b0;
      res_wr      <= 1'b0;
      res_rd      <= '0;
      res_data    <= '0;
      flags       <= '0;
    end else begin
      if (w_accept) begin
        alu_cond    <= instr[31:28];
        alu_opcode  <= instr[27:24];
        alu_s       <= instr[23];
        r_rd        <= instr[22:19];
        alu_in1     <= r_regs[instr[18:15]];
        alu_in2     <= r_regs[instr[14:11]];
        alu_sr_cont <= instr[10:8];
        alu_sr_bit  <= instr[7:3];
        alu_imm     <= instr[15:0];
      end
      if (w_wr) r_regs[r_rd] <= alu_out;
      if (w_fl) flags <= alu_flags;
      if (r_state == EXEC) begin
        res_data <= alu_out;
        res_rd   <= r_rd;
      end
      res_wr    <= w_wr;
      res_valid <= r_state == EXEC;
    end
  assign dbg_data = r_regs[dbg_addr];
endmodule
